// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Instruction-fetch sequencer. Owns the PC, addresses a
//            combinational instruction ROM and registers each returned word
//            into an instruction register with a valid flag for decode.
//            Handles start, stall, redirect, external halt, halt-opcode
//            detection and end-of-memory wrap or overrun.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = 16'hFFFF,
    parameter bit                 WRAP_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted,
    output logic              overrun,
    output logic [15:0]       fetch_count
);

    localparam logic [1:0]        c_ST_IDLE   = 2'd0;
    localparam logic [1:0]        c_ST_RUN    = 2'd1;
    localparam logic [1:0]        c_ST_HALTED = 2'd2;
    localparam logic [ADDR_W-1:0] c_PC_MAX    = {ADDR_W{1'b1}};
    localparam logic [15:0]       c_CNT_MAX   = 16'hFFFF;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_halted;
    logic              r_overrun;
    logic [15:0]       r_fetch_count;

    // Saturating increment of the issued-instruction counter
    logic [15:0] w_count_inc;
    assign w_count_inc = (r_fetch_count == c_CNT_MAX) ? r_fetch_count
                                                      : r_fetch_count + 16'd1;

    // Fetch FSM: every output is a register, ROM address is the PC itself
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_overrun     <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state       <= c_ST_RUN;
                        r_pc          <= RESET_PC;
                        r_fetch_count <= '0;
                    end
                end

                c_ST_RUN: begin
                    if (halt_req) begin
                        r_state       <= c_ST_HALTED;
                        r_halted      <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end else if (redirect) begin
                        // Word fetched this cycle is wrong-path; drop it
                        r_pc          <= redirect_pc;
                        r_instr_valid <= 1'b0;
                    end else if (!stall) begin
                        r_instr       <= imem_data;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_fetch_count <= w_count_inc;
                        if (imem_data == HALT_WORD) begin
                            r_state  <= c_ST_HALTED;
                            r_halted <= 1'b1;
                        end else if (r_pc == c_PC_MAX) begin
                            if (WRAP_EN) begin
                                r_pc <= '0;
                            end else begin
                                r_state   <= c_ST_HALTED;
                                r_halted  <= 1'b1;
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end

                c_ST_HALTED: begin
                    if (start) begin
                        r_state       <= c_ST_RUN;
                        r_halted      <= 1'b0;
                        r_pc          <= RESET_PC;
                        r_fetch_count <= '0;
                        r_overrun     <= 1'b0;
                        r_instr_valid <= 1'b0;
                    end else if (!stall) begin
                        // Last word is consumed by decode on the first non-stalled cycle
                        r_instr_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= c_ST_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign overrun     = r_overrun;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Self-checking bench for imem_fetch_ctrl. Two instances share
//            stimulus: one with PC wrap enabled, one with overrun on wrap.
//            Issued words are scoreboarded against the wrap instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt_req;

    logic [15:0] rom [256];

    logic [7:0]  w_wr_addr, w_wr_ipc, w_ov_addr, w_ov_ipc;
    logic [15:0] w_wr_data, w_wr_instr, w_ov_data, w_ov_instr;
    logic        w_wr_valid, w_wr_halted, w_wr_overrun;
    logic        w_ov_valid, w_ov_halted, w_ov_overrun;
    logic [15:0] w_wr_count, w_ov_count;

    assign w_wr_data = rom[w_wr_addr];
    assign w_ov_data = rom[w_ov_addr];

    imem_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .HALT_WORD(16'hFFFF), .WRAP_EN(1'b1)
    ) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_addr(w_wr_addr),
        .imem_data(w_wr_data), .instr(w_wr_instr), .instr_pc(w_wr_ipc),
        .instr_valid(w_wr_valid), .halted(w_wr_halted), .overrun(w_wr_overrun),
        .fetch_count(w_wr_count)
    );

    imem_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .HALT_WORD(16'hFFFF), .WRAP_EN(1'b0)
    ) dut_ovr (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_addr(w_ov_addr),
        .imem_data(w_ov_data), .instr(w_ov_instr), .instr_pc(w_ov_ipc),
        .instr_valid(w_ov_valid), .halted(w_ov_halted), .overrun(w_ov_overrun),
        .fetch_count(w_ov_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Monitor: a new word is issued when valid is set after an edge where
    // either valid was low or decode was not stalling
    logic r_mon_valid, r_mon_stall;
    logic [23:0] r_mon_exp;
    always @(posedge clk) begin
        r_mon_valid = w_wr_valid;
        r_mon_stall = stall;
        #1;
        if (!rst && w_wr_valid && (!r_mon_valid || !r_mon_stall)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {8'h0, w_wr_ipc, w_wr_instr}, 32'hFFFFFFFF);
            end else begin
                r_mon_exp = sb_q.pop_front();
                check("sb_word", {8'h0, w_wr_ipc, w_wr_instr}, {8'h0, r_mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic s_start, input logic s_stall, input logic s_redir,
                         input logic [7:0] s_rpc, input logic s_halt);
        start       = s_start;
        stall       = s_stall;
        redirect    = s_redir;
        redirect_pc = s_rpc;
        halt_req    = s_halt;
    endtask

    // One plain fetch cycle from a known address; the word is expected next edge
    task automatic fetch_cycle(input logic [7:0] a);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("fetch_addr", {24'h0, w_wr_addr}, {24'h0, a});
        sb_q.push_back({a, rom[a]});
        tick();
    endtask

    task automatic check_reset_vals();
        check("rst_addr",    {24'h0, w_wr_addr},    32'h0);
        check("rst_instr",   {16'h0, w_wr_instr},   32'h0);
        check("rst_ipc",     {24'h0, w_wr_ipc},     32'h0);
        check("rst_valid",   {31'h0, w_wr_valid},   32'h0);
        check("rst_halted",  {31'h0, w_wr_halted},  32'h0);
        check("rst_overrun", {31'h0, w_wr_overrun}, 32'h0);
        check("rst_count",   {16'h0, w_wr_count},   32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {~i[7:0], i[7:0]};
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        rom[6] = 16'hFFFF;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(); tick();
        check_reset_vals();
        rst = 1'b0;

        // Idle without start: nothing fetched
        tick();
        check("idle_valid", {31'h0, w_wr_valid}, 32'h0);

        // Start: first edge enters RUN, second edge registers ROM[0]
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("start_e1_valid", {31'h0, w_wr_valid}, 32'h0);
        fetch_cycle(8'h00);
        check("start_e2_valid", {31'h0, w_wr_valid}, 32'h1);
        fetch_cycle(8'h01);

        // Stall three cycles holding 2222/1
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            check("stall_instr", {16'h0, w_wr_instr}, 32'h2222);
            check("stall_ipc",   {24'h0, w_wr_ipc},   32'h1);
            check("stall_addr",  {24'h0, w_wr_addr},  32'h2);
            check("stall_count", {16'h0, w_wr_count}, 32'h2);
        end
        fetch_cycle(8'h02);
        fetch_cycle(8'h03);
        check("count4", {16'h0, w_wr_count}, 32'h4);
        fetch_cycle(8'h04);

        // Redirect wins over stall
        drive(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
        tick();
        check("redir_valid", {31'h0, w_wr_valid}, 32'h0);
        check("redir_addr",  {24'h0, w_wr_addr},  32'h40);
        fetch_cycle(8'h40);
        fetch_cycle(8'h41);
        check("count7", {16'h0, w_wr_count}, 32'h7);

        // Halt word at address 6
        drive(1'b0, 1'b0, 1'b1, 8'h06, 1'b0);
        tick();
        fetch_cycle(8'h06);
        check("hw_halted", {31'h0, w_wr_halted}, 32'h1);
        check("hw_valid",  {31'h0, w_wr_valid},  32'h1);
        check("hw_addr",   {24'h0, w_wr_addr},   32'h6);
        check("hw_count",  {16'h0, w_wr_count},  32'h8);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check("hw_hold_valid", {31'h0, w_wr_valid}, 32'h1);
        drive(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
        tick();
        check("hw_drop_valid", {31'h0, w_wr_valid}, 32'h0);
        check("hw_drop_addr",  {24'h0, w_wr_addr},  32'h6);

        // Restart from HALTED
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("rs_halted", {31'h0, w_wr_halted}, 32'h0);
        check("rs_count",  {16'h0, w_wr_count},  32'h0);
        check("rs_addr",   {24'h0, w_wr_addr},   32'h0);
        fetch_cycle(8'h00);
        check("rs_count1", {16'h0, w_wr_count}, 32'h1);

        // End of memory: wrap vs overrun
        drive(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        tick();
        fetch_cycle(8'hFF);
        check("ov_ipc",     {24'h0, w_ov_ipc},     32'hFF);
        check("ov_valid",   {31'h0, w_ov_valid},   32'h1);
        check("ov_halted",  {31'h0, w_ov_halted},  32'h1);
        check("ov_overrun", {31'h0, w_ov_overrun}, 32'h1);
        check("ov_addr",    {24'h0, w_ov_addr},    32'hFF);
        check("wr_overrun", {31'h0, w_wr_overrun}, 32'h0);
        fetch_cycle(8'h00);
        check("ov_sticky",  {31'h0, w_ov_overrun}, 32'h1);

        // halt_req beats redirect
        drive(1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
        tick();
        check("hr_halted", {31'h0, w_wr_halted}, 32'h1);
        check("hr_valid",  {31'h0, w_wr_valid},  32'h0);
        check("hr_addr",   {24'h0, w_wr_addr},   32'h1);

        // start clears overrun
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("ov_clear",   {31'h0, w_ov_overrun}, 32'h0);
        check("ov_resume",  {31'h0, w_ov_halted},  32'h0);
        fetch_cycle(8'h00);
        fetch_cycle(8'h01);

        // Reset mid-run with stall and redirect asserted
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
        tick();
        check_reset_vals();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();

        check("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
